// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU fetch path.
//   OP_JMP / OP_JNC : opcodes that redirect the program counter
//   fetch_state_t   : instr_fetch FSM states
//   ADDR_W_DEF / DATA_W_DEF : default PC/ROM address and instruction widths
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [3:0] OP_JMP = 4'b1111;
  localparam logic [3:0] OP_JNC = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_ISSUE,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection.
//   opcode, imm : decoded instruction fields
//   cur_pc      : address the instruction was fetched from
//   carry       : ALU carry flag
//   next_pc     : JMP -> imm; JNC with carry clear -> imm; otherwise cur_pc+1 (wraps)
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [3:0]        opcode,
  input  logic [3:0]        imm,
  input  logic [ADDR_W-1:0] cur_pc,
  input  logic              carry,
  output logic [ADDR_W-1:0] next_pc
);

  always_comb begin
    next_pc = cur_pc + ADDR_W'(1);
    if ((opcode == OP_JMP) || ((opcode == OP_JNC) && !carry)) begin
      next_pc = ADDR_W'(imm);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads one word from ROM at pc_in over a req/ack
// handshake, holds it in the instruction register, computes the next PC and
// hands it back to program_counter with a one-cycle pc_load strobe.
//   clk, rst_n          : clock, asynchronous active-low reset
//   pc_in               : current PC from program_counter
//   carry_flag          : ALU carry, sampled in DECODE
//   rom_addr/rom_req    : ROM read address / request
//   rom_ack/rom_data    : ROM data valid / read data
//   stall               : downstream not ready
//   ir_valid,opcode,imm : decoded instruction, valid while issuing
//   next_pc, pc_load    : PC to load into program_counter and its strobe
//   fetch_err           : sticky ROM timeout flag
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              carry_flag,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              stall,
  output logic              ir_valid,
  output logic [3:0]        opcode,
  output logic [3:0]        imm,
  output logic [ADDR_W-1:0] next_pc,
  output logic              pc_load,
  output logic              fetch_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t      state, state_nxt;
  logic [DATA_W-1:0] ir;
  logic [CNT_W-1:0]  wait_cnt;
  logic              timeout_hit;
  logic [ADDR_W-1:0] calc_pc;

  assign opcode = ir[DATA_W-1 -: 4];
  assign imm    = ir[3:0];

  // Counter holds the number of ack-less WAIT cycles already spent; the
  // current cycle is the TIMEOUT-th one when it reads TIMEOUT-1.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Handshake/issue strobes decode straight from the state register so that
  // the asynchronous reset clears them immediately.
  assign rom_req  = (state == S_WAIT);
  assign ir_valid = (state == S_ISSUE);
  assign pc_load  = (state == S_ISSUE) && !stall;

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_calc (
    .opcode (opcode),
    .imm    (imm),
    .cur_pc (rom_addr),
    .carry  (carry_flag),
    .next_pc(calc_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (rom_ack) begin
          state_nxt = S_DECODE;
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
        end
      end
      S_DECODE: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (!stall) begin
          state_nxt = S_FETCH;
        end
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir        <= '0;
      rom_addr  <= '0;
      next_pc   <= '0;
      fetch_err <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          rom_addr <= pc_in;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (rom_ack) begin
            ir <= rom_data;
          end else if (timeout_hit) begin
            fetch_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: next_pc <= calc_pc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a driver acts as ROM and program_counter
// and pushes the expected instruction into a scoreboard; a monitor pops and
// compares whenever the DUT strobes pc_load.
module tb_instr_fetch;

  localparam int unsigned TIMEOUT = 15;

  logic       clk;
  logic       rst_n;
  logic [3:0] pc_in;
  logic       carry_flag;
  logic [3:0] rom_addr;
  logic       rom_req;
  logic       rom_ack;
  logic [7:0] rom_data;
  logic       stall;
  logic       ir_valid;
  logic [3:0] opcode;
  logic [3:0] imm;
  logic [3:0] next_pc;
  logic       pc_load;
  logic       fetch_err;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] op;
    logic [3:0] imm;
    logic [3:0] nxt;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  instr_fetch #(
    .ADDR_W (4),
    .DATA_W (8),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_in     (pc_in),
    .carry_flag(carry_flag),
    .rom_addr  (rom_addr),
    .rom_req   (rom_req),
    .rom_ack   (rom_ack),
    .rom_data  (rom_data),
    .stall     (stall),
    .ir_valid  (ir_valid),
    .opcode    (opcode),
    .imm       (imm),
    .next_pc   (next_pc),
    .pc_load   (pc_load),
    .fetch_err (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: jumps go to the immediate, everything else to the next word.
  function automatic logic [3:0] ref_next(input logic [3:0] pc, input logic [7:0] w, input bit c);
    int op;
    int tgt;
    int p;
    op  = int'(w) / 16;
    tgt = int'(w) % 16;
    p   = int'(pc);
    if (op == 15) return 4'(tgt);
    if (op == 14 && c == 1'b0) return 4'(tgt);
    return 4'((p + 1) % 16);
  endfunction

  // Monitor: compare the issued instruction against the scoreboard.
  initial begin
    exp_t e;
    bit   prev_load;
    prev_load = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_load = 1'b0;
        continue;
      end
      if (pc_load) begin
        check("load_implies_valid", ir_valid, 1);
        check("load_not_back_to_back", prev_load, 0);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: pc_load with no expected instruction at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("rom_addr", rom_addr, e.addr);
          check("opcode", opcode, e.op);
          check("imm", imm, e.imm);
          check("next_pc", next_pc, e.nxt);
        end
      end else if (ir_valid && sb.size() > 0) begin
        check("stall_opcode", opcode, sb[0].op);
        check("stall_next_pc", next_pc, sb[0].nxt);
      end
      prev_load = pc_load;
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    rom_ack    = 1'b0;
    rom_data   = '0;
    stall      = 1'b0;
    carry_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_addr", rom_addr, 0);
    check("rst_rom_req", rom_req, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_pc_load", pc_load, 0);
    check("rst_next_pc", next_pc, 0);
    check("rst_fetch_err", fetch_err, 0);
    check("rst_opcode", opcode, 0);
    rst_n = 1'b1;
  endtask

  // One instruction: acts as ROM (ack after d extra wait cycles), holds
  // stall for st issue cycles, then updates pc_in as program_counter would.
  task automatic run_instr(input logic [7:0] w, input int d, input bit c,
                           input int st, input int force_pc);
    exp_t e;
    int   n;
    bit   got;
    if (force_pc >= 0) pc_in = 4'(force_pc);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rom_req) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL req_timeout: rom_req never asserted at %0t", $time);
      return;
    end
    check("fetch_addr", rom_addr, pc_in);
    e.addr = pc_in;
    e.op   = w[7:4];
    e.imm  = w[3:0];
    e.nxt  = ref_next(pc_in, w, c);
    n = 1;
    repeat (d) begin
      @(posedge clk);
      #1;
      if (rom_req) n++;
      check("addr_stable", rom_addr, e.addr);
    end
    rom_data   = w;
    rom_ack    = 1'b1;
    carry_flag = c;
    stall      = (st > 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    rom_ack  = 1'b0;
    rom_data = 8'($urandom);
    check("req_drop", rom_req, 0);
    check("req_cycles", n, d + 1);
    @(posedge clk);
    #1;
    check("issue_valid", ir_valid, 1);
    check("issue_load", pc_load, (st == 0));
    if (st > 0) begin
      repeat (st - 1) begin
        @(posedge clk);
        #1;
        check("stall_valid", ir_valid, 1);
        check("stall_no_load", pc_load, 0);
      end
      @(posedge clk);
      #1;
      stall = 1'b0;
      #1;
      check("unstall_load", pc_load, 1);
    end
    @(posedge clk);
    #1;
    pc_in = e.nxt;
  endtask

  initial begin
    int         n;
    logic [7:0] w;
    vectors     = 0;
    miscompares = 0;
    pc_in       = '0;

    do_reset();
    // Directed: sequential, wrap, JMP, JNC taken / not taken.
    run_instr(8'h00, 0, 1'b0, 0, 3);
    run_instr(8'h00, 0, 1'b0, 0, 15);
    run_instr(8'hF9, 0, 1'b0, 0, -1);
    run_instr(8'hE5, 0, 1'b0, 0, -1);
    run_instr(8'hE5, 0, 1'b1, 0, 7);
    // Slow ROM plus stall.
    run_instr(8'h12, 3, 1'b0, 5, -1);

    // Back-to-back NOPs from pc 0.
    do_reset();
    pc_in = '0;
    for (int i = 0; i < 5; i++) run_instr(8'h00, 0, 1'b0, 0, -1);

    // Randomized program with jump bias.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       w = {4'hF, 4'($urandom)};
        1:       w = {4'hE, 4'($urandom)};
        default: w = 8'($urandom);
      endcase
      run_instr(w, int'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, 3)), -1);
    end

    // Timeout: never acknowledge.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rom_req) n++;
      else if (n > 0) break;
    end
    check("timeout_req_cycles", n, TIMEOUT);
    check("timeout_err", fetch_err, 1);
    check("timeout_req_low", rom_req, 0);
    rom_ack = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      check("halt_req", rom_req, 0);
      check("halt_valid", ir_valid, 0);
      check("halt_load", pc_load, 0);
      check("halt_err", fetch_err, 1);
    end
    rom_ack = 1'b0;

    // Async reset from HALT, between edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_err", fetch_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pc_in = 4'd9;
    @(posedge clk);
    #1;
    check("post_rst_fetch_req", rom_req, 0);
    @(posedge clk);
    #1;
    check("post_rst_wait_req", rom_req, 1);
    check("post_rst_addr", rom_addr, 9);
    // Async reset mid-WAIT.
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_req", rom_req, 0);
    check("areset_valid", ir_valid, 0);
    check("areset_load", pc_load, 0);
    check("areset_err2", fetch_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(8'h00, 1, 1'b0, 0, 5);

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
